// File: rtl/el2_pkg.sv
// el2_pkg: shared types for the DCCM store write buffer
package el2_pkg;
    typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} el2_wrbuf_state_e;
endpackage

// File: rtl/el2_lsu_dccm_wrbuf_fwd.sv
// el2_lsu_dccm_wrbuf_fwd: per-byte youngest-match store-to-load forwarding
module el2_lsu_dccm_wrbuf_fwd #(
    parameter int DEPTH = 4,
    parameter int AW = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic [DEPTH-1:0]                      vld,
    input  logic [DEPTH-1:0][AW-1:0]              addr,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0]      data,
    input  logic [DEPTH-1:0][DATA_WIDTH/8-1:0]    be,
    input  logic [$clog2(DEPTH)-1:0]              rd_ptr,
    input  logic [AW-1:0]                         ld_waddr,
    output logic [DATA_WIDTH/8-1:0]               fwd_byteen,
    output logic [DATA_WIDTH-1:0]                 fwd_data
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] idx;
    // walk entries oldest to youngest so younger hits overwrite older ones per lane
    always_comb begin
        fwd_byteen = '0;
        fwd_data = '0;
        idx = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            for (int j = 0; j < DATA_WIDTH/8; j++) begin
                if (vld[idx] && addr[idx] == ld_waddr && be[idx][j]) begin
                    fwd_byteen[j] = 1'b1;
                    fwd_data[8*j +: 8] = data[idx][8*j +: 8];
                end
            end
        end
    end
endmodule

// File: rtl/el2_lsu_dccm_wrbuf.sv
// el2_lsu_dccm_wrbuf: DCCM store write buffer with read-modify-write and load forwarding
module el2_lsu_dccm_wrbuf
    import el2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DCCM_BITS = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         st_valid,
    output logic                         st_ready,
    input  logic [DCCM_BITS-1:0]         st_addr,
    input  logic [DATA_WIDTH-1:0]        st_data,
    input  logic [DATA_WIDTH/8-1:0]      st_byteen,
    input  logic                         ld_req,
    input  logic [DCCM_BITS-1:0]         ld_addr,
    output logic [DATA_WIDTH/8-1:0]      fwd_byteen,
    output logic [DATA_WIDTH-1:0]        fwd_data,
    output logic                         dccm_rden,
    output logic [DCCM_BITS-1:0]         dccm_rd_addr,
    input  logic [DATA_WIDTH-1:0]        dccm_rd_data,
    output logic                         dccm_wren,
    output logic [DCCM_BITS-1:0]         dccm_wr_addr,
    output logic [DATA_WIDTH-1:0]        dccm_wr_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int BE = DATA_WIDTH/8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = DCCM_BITS-2;

    logic [DEPTH-1:0][AW-1:0]         addr_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
    logic [DEPTH-1:0][BE-1:0]         be_q;
    logic [DEPTH-1:0]                 vld_q;
    logic [PW-1:0]                    wr_ptr, rd_ptr;
    logic [CW-1:0]                    count_q;
    el2_wrbuf_state_e                 state;
    logic [DATA_WIDTH-1:0]            merge_q, merged;
    logic [BE-1:0]                    hbe;
    logic                             idle_go, push, pop, unused_bits;

    assign hbe = be_q[rd_ptr];
    assign count = count_q;
    assign empty = rst || count_q == '0;
    assign st_ready = rst || count_q != CW'(DEPTH);
    assign push = st_valid && st_ready;
    assign idle_go = !rst && state == IDLE && count_q != '0 && !ld_req;
    assign dccm_wren = (idle_go && (&hbe)) || (!rst && state == RMW_WR && !ld_req);
    assign dccm_rden = idle_go && !(&hbe) && (|hbe);
    assign pop = dccm_wren || (idle_go && ~|hbe);
    assign dccm_rd_addr = {addr_q[rd_ptr], 2'b00};
    assign dccm_wr_addr = {addr_q[rd_ptr], 2'b00};
    assign dccm_wr_data = state == RMW_WR ? merge_q : data_q[rd_ptr];
    assign unused_bits = ^{st_addr[1:0], ld_addr[1:0]};

    // overlay the head's enabled bytes onto the word read back from DCCM
    always_comb begin
        merged = dccm_rd_data;
        for (int j = 0; j < BE; j++)
            if (hbe[j]) merged[8*j +: 8] = data_q[rd_ptr][8*j +: 8];
    end

    // control: RMW sequencing, FIFO pointers, occupancy and valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count_q <= '0;
            vld_q <= '0;
        end else begin
            state <= state == IDLE ? (dccm_rden ? RMW_RD : IDLE) :
                     state == RMW_RD ? RMW_WR : (ld_req ? RMW_WR : IDLE);
            if (push) begin
                vld_q[wr_ptr] <= 1'b1;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // entry payload and merged RMW word are plain storage without reset
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= st_addr[DCCM_BITS-1:2];
            data_q[wr_ptr] <= st_data;
            be_q[wr_ptr] <= st_byteen;
        end
        if (state == RMW_RD) merge_q <= merged;
    end

    el2_lsu_dccm_wrbuf_fwd #(.DEPTH(DEPTH), .AW(AW), .DATA_WIDTH(DATA_WIDTH)) u_fwd (
        .vld(vld_q & {DEPTH{!rst}}),
        .addr(addr_q),
        .data(data_q),
        .be(be_q),
        .rd_ptr(rd_ptr),
        .ld_waddr(ld_addr[DCCM_BITS-1:2]),
        .fwd_byteen(fwd_byteen),
        .fwd_data(fwd_data)
    );
endmodule

// File: tb/tb_el2_lsu_dccm_wrbuf.sv
// tb_el2_lsu_dccm_wrbuf: directed and randomized checks of the DCCM write buffer
module tb_el2_lsu_dccm_wrbuf;
    logic        clk = 0, rst, st_valid, st_ready, ld_req;
    logic [15:0] st_addr, ld_addr, dccm_rd_addr, dccm_wr_addr;
    logic [31:0] st_data, fwd_data, dccm_rd_data, dccm_wr_data;
    logic [3:0]  st_byteen, fwd_byteen;
    logic        dccm_rden, dccm_wren, empty;
    logic [2:0]  count;
    int n_run = 0, n_fail = 0;

    typedef struct {logic [13:0] wa; logic [31:0] d; logic [3:0] be;} st_t;
    st_t q[$];
    logic [31:0] env_mem [int];
    logic [31:0] ref_mem [int];
    logic        rd_pend = 0;
    logic [15:0] rd_a = 0;

    el2_lsu_dccm_wrbuf dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_byteen(st_byteen), .ld_req(ld_req), .ld_addr(ld_addr),
        .fwd_byteen(fwd_byteen), .fwd_data(fwd_data), .dccm_rden(dccm_rden),
        .dccm_rd_addr(dccm_rd_addr), .dccm_rd_data(dccm_rd_data), .dccm_wren(dccm_wren),
        .dccm_wr_addr(dccm_wr_addr), .dccm_wr_data(dccm_wr_data), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_init(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction
    function automatic logic [31:0] env_rd(input int a);
        return env_mem.exists(a) ? env_mem[a] : mem_init(a);
    endfunction
    function automatic logic [31:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] d, input logic [3:0] be, input logic [31:0] cur);
        logic [31:0] r = cur;
        for (int j = 0; j < 4; j++) if (be[j]) r[8*j +: 8] = d[8*j +: 8];
        return r;
    endfunction

    // DCCM model: captures writes and answers reads one cycle after the request
    always @(negedge clk) begin
        rd_pend = dccm_rden;
        rd_a = dccm_rd_addr;
        if (dccm_wren) env_mem[int'(dccm_wr_addr[15:2])] = dccm_wr_data;
    end
    always @(posedge clk) begin
        #1;
        dccm_rd_data = rd_pend ? env_rd(int'(rd_a[15:2])) : $urandom;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = v; st_addr = a; st_data = d; st_byteen = be;
    endtask

    task automatic test_reset;
        rst = 1; drive(0, 0, 0, 0); ld_req = 0; ld_addr = 0;
        tick; tick;
        @(negedge clk);
        n_run++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_st_ready got %b want 1", st_ready); end
        n_run++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_run++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_run++; if ({dccm_rden, dccm_wren} !== 2'b00) begin n_fail++; $display("FAIL reset_access got %b want 00", {dccm_rden, dccm_wren}); end
        n_run++; if (fwd_byteen !== 4'h0) begin n_fail++; $display("FAIL reset_fwd got %h want 0", fwd_byteen); end
        tick; rst = 0;
    endtask

    task automatic test_full_word;
        ld_req = 0; drive(1, 16'h0100, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        n_run++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL fw_ready got %b want 1", st_ready); end
        tick; st_valid = 0;
        @(negedge clk);
        n_run++; if ({dccm_wren, dccm_rden, dccm_wr_addr, dccm_wr_data} !== {2'b10, 16'h0100, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL fw_write got wren=%b rden=%b addr=%h data=%h want 1 0 0100 deadbeef", dccm_wren, dccm_rden, dccm_wr_addr, dccm_wr_data); end
        tick;
        @(negedge clk);
        n_run++; if ({empty, dccm_wren} !== 2'b10) begin n_fail++; $display("FAIL fw_empty got empty=%b wren=%b want 1 0", empty, dccm_wren); end
        tick;
    endtask

    task automatic test_zero_be;
        drive(1, 16'h0180, 32'h55555555, 4'h0);
        tick; st_valid = 0;
        @(negedge clk);
        n_run++; if ({count, dccm_rden, dccm_wren} !== {3'd1, 2'b00}) begin
            n_fail++; $display("FAIL zero_be got count=%0d rden=%b wren=%b want 1 0 0", count, dccm_rden, dccm_wren); end
        tick;
        @(negedge clk);
        n_run++; if (empty !== 1'b1) begin n_fail++; $display("FAIL zero_be_empty got %b want 1", empty); end
        tick;
    endtask

    task automatic test_partial;
        env_mem[16'h0204 >> 2] = 32'h11223344;
        drive(1, 16'h0204, 32'h000000AA, 4'h1);
        tick; st_valid = 0;
        @(negedge clk);
        n_run++; if ({dccm_rden, dccm_wren, dccm_rd_addr} !== {2'b10, 16'h0204}) begin
            n_fail++; $display("FAIL rmw_read got rden=%b wren=%b addr=%h want 1 0 0204", dccm_rden, dccm_wren, dccm_rd_addr); end
        tick;
        @(negedge clk);
        n_run++; if ({dccm_rden, dccm_wren} !== 2'b00) begin n_fail++; $display("FAIL rmw_rd_idle got %b want 00", {dccm_rden, dccm_wren}); end
        tick;
        @(negedge clk);
        n_run++; if ({dccm_wren, dccm_wr_addr, dccm_wr_data} !== {1'b1, 16'h0204, 32'h112233AA}) begin
            n_fail++; $display("FAIL rmw_write got wren=%b addr=%h data=%h want 1 0204 112233aa", dccm_wren, dccm_wr_addr, dccm_wr_data); end
        tick;
        @(negedge clk);
        n_run++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rmw_empty got %b want 1", empty); end
        tick;
    endtask

    task automatic test_full_stall;
        ld_req = 1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'(16'h0400 + 4*i), 32'hA0000000 + 32'(i), 4'hF);
            tick;
        end
        drive(1, 16'h0410, 32'hBAD0BAD0, 4'hF);
        @(negedge clk);
        n_run++; if ({st_ready, count} !== {1'b0, 3'd4}) begin n_fail++; $display("FAIL full got ready=%b count=%0d want 0 4", st_ready, count); end
        tick; st_valid = 0; ld_req = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_run++; if ({dccm_wren, dccm_wr_addr, dccm_wr_data} !== {1'b1, 16'(16'h0400 + 4*i), 32'hA0000000 + 32'(i)}) begin
                n_fail++; $display("FAIL drain_%0d got wren=%b addr=%h data=%h", i, dccm_wren, dccm_wr_addr, dccm_wr_data); end
            tick;
        end
        @(negedge clk);
        n_run++; if ({empty, dccm_wren} !== 2'b10) begin n_fail++; $display("FAIL full_drained got empty=%b wren=%b want 1 0", empty, dccm_wren); end
        tick;
    endtask

    task automatic test_forward;
        int c = 0;
        ld_req = 1; ld_addr = 0;
        drive(1, 16'h0300, 32'h000000FF, 4'h1); tick;
        drive(1, 16'h0300, 32'h0000EE00, 4'h3); tick;
        st_valid = 0; ld_addr = 16'h0302;
        @(negedge clk);
        n_run++; if ({fwd_byteen, fwd_data} !== {4'h3, 32'h0000EE00}) begin
            n_fail++; $display("FAIL fwd_young got be=%h data=%h want 3 0000ee00", fwd_byteen, fwd_data); end
        tick;
        drive(1, 16'h0300, 32'h12345678, 4'hF); ld_addr = 16'h0300;
        @(negedge clk);
        n_run++; if ({fwd_byteen, fwd_data} !== {4'h3, 32'h0000EE00}) begin
            n_fail++; $display("FAIL fwd_same_cycle got be=%h data=%h want 3 0000ee00", fwd_byteen, fwd_data); end
        tick; st_valid = 0;
        @(negedge clk);
        n_run++; if ({fwd_byteen, fwd_data} !== {4'hF, 32'h12345678}) begin
            n_fail++; $display("FAIL fwd_next got be=%h data=%h want f 12345678", fwd_byteen, fwd_data); end
        tick; ld_addr = 16'h0304;
        @(negedge clk);
        n_run++; if ({fwd_byteen, fwd_data} !== 36'h0) begin n_fail++; $display("FAIL fwd_miss got be=%h data=%h want 0 0", fwd_byteen, fwd_data); end
        tick; ld_req = 0;
        while (!empty && c < 20) begin tick; c++; end
        n_run++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fwd_drain_timeout got empty=%b want 1", empty); end
    endtask

    task automatic test_rmw_stall;
        env_mem[16'h0500 >> 2] = 32'h01020304;
        ld_req = 0; drive(1, 16'h0500, 32'h0000BB00, 4'h2);
        tick; st_valid = 0;
        @(negedge clk);
        n_run++; if (dccm_rden !== 1'b1) begin n_fail++; $display("FAIL stall_rden got %b want 1", dccm_rden); end
        tick; ld_req = 1;
        @(negedge clk);
        n_run++; if ({dccm_rden, dccm_wren} !== 2'b00) begin n_fail++; $display("FAIL stall_rd got %b want 00", {dccm_rden, dccm_wren}); end
        for (int i = 0; i < 3; i++) begin
            tick;
            @(negedge clk);
            n_run++; if (dccm_wren !== 1'b0) begin n_fail++; $display("FAIL stall_wr_%0d got wren=%b want 0", i, dccm_wren); end
        end
        tick; ld_req = 0;
        @(negedge clk);
        n_run++; if ({dccm_wren, dccm_wr_data} !== {1'b1, 32'h0102BB04}) begin
            n_fail++; $display("FAIL stall_release got wren=%b data=%h want 1 0102bb04", dccm_wren, dccm_wr_data); end
        tick;
    endtask

    task automatic test_reset_rmw;
        ld_req = 0; drive(1, 16'h0600, 32'h00CC0000, 4'h4);
        tick; st_valid = 0;
        tick; ld_req = 1;
        tick; rst = 1; ld_req = 0;
        @(negedge clk);
        n_run++; if (dccm_wren !== 1'b0) begin n_fail++; $display("FAIL rst_rmw_wren got %b want 0", dccm_wren); end
        tick; rst = 0;
        @(negedge clk);
        n_run++; if ({dccm_wren, count, empty} !== {1'b0, 3'd0, 1'b1}) begin
            n_fail++; $display("FAIL rst_rmw_after got wren=%b count=%0d empty=%b want 0 0 1", dccm_wren, count, empty); end
        tick;
    endtask

    task automatic rand_cycle(input logic v, input logic lr);
        logic acc;
        logic [3:0] efb;
        logic [31:0] efd, ew;
        drive(v, 16'(16'h1000 + 4*$urandom_range(0, 7) + $urandom_range(0, 3)), $urandom, 4'($urandom_range(1, 15)));
        ld_req = lr;
        ld_addr = 16'(16'h1000 + 4*$urandom_range(0, 7) + $urandom_range(0, 3));
        @(negedge clk);
        acc = st_valid && q.size() != 4;
        n_run++; if ((ld_req && (dccm_rden || dccm_wren)) || (dccm_rden && dccm_wren)) begin
            n_fail++; $display("FAIL rnd_access got ld=%b rden=%b wren=%b", ld_req, dccm_rden, dccm_wren); end
        n_run++; if (count !== 3'(q.size())) begin n_fail++; $display("FAIL rnd_count got %0d want %0d", count, q.size()); end
        n_run++; if (st_ready !== (q.size() != 4)) begin n_fail++; $display("FAIL rnd_ready got %b want %b", st_ready, q.size() != 4); end
        if (ld_req) begin
            efb = 0; efd = 0;
            for (int k = 0; k < q.size(); k++)
                if (q[k].wa == ld_addr[15:2])
                    for (int j = 0; j < 4; j++)
                        if (q[k].be[j]) begin efb[j] = 1; efd[8*j +: 8] = q[k].d[8*j +: 8]; end
            n_run++; if ({fwd_byteen, fwd_data} !== {efb, efd}) begin
                n_fail++; $display("FAIL rnd_fwd addr=%h got be=%h data=%h want be=%h data=%h", ld_addr, fwd_byteen, fwd_data, efb, efd); end
        end
        if (dccm_rden) begin
            n_run++; if (q.size() == 0 || dccm_rd_addr !== {q[0].wa, 2'b00}) begin
                n_fail++; $display("FAIL rnd_rd_addr got %h pending=%0d", dccm_rd_addr, q.size()); end
        end
        if (dccm_wren) begin
            n_run++;
            if (q.size() == 0) begin n_fail++; $display("FAIL rnd_spurious_write got addr=%h want none", dccm_wr_addr); end
            else begin
                ew = merge(q[0].d, q[0].be, ref_rd(int'(q[0].wa)));
                if ({dccm_wr_addr, dccm_wr_data} !== {q[0].wa, 2'b00, ew}) begin
                    n_fail++; $display("FAIL rnd_write got addr=%h data=%h want addr=%h data=%h", dccm_wr_addr, dccm_wr_data, {q[0].wa, 2'b00}, ew); end
                ref_mem[int'(q[0].wa)] = ew;
                void'(q.pop_front());
            end
        end
        if (acc) q.push_back('{st_addr[15:2], st_data, st_byteen});
        tick;
    endtask

    task automatic test_random;
        q.delete();
        for (int i = 0; i < 600; i++) rand_cycle($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 60; i++) rand_cycle(1'b0, 1'b0);
        @(negedge clk);
        n_run++; if ({empty, 3'(q.size())} !== 4'b1000) begin n_fail++; $display("FAIL rnd_final got empty=%b pending=%0d want 1 0", empty, q.size()); end
        tick;
    endtask

    initial begin
        dccm_rd_data = 0;
        test_reset;
        test_full_word;
        test_zero_be;
        test_partial;
        test_full_stall;
        test_forward;
        test_rmw_stall;
        test_reset_rmw;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
